ifetch_queue: RTL

Parametrised successor to the single-register fetch stage.
- Drives one-outstanding requests to the icache and pre-decodes direct jumps, redirecting fetch with no bubble.
- Stalls on indirect jumps until their target resolves, and queries the branch predictor for everything else.
- Buffers fetched instructions in a DEPTH-entry FIFO so the decoder is decoupled by a valid/ready handshake.
- Sits between the icache, the branch predictor, the decoder and the ROB/ALU redirect sources.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/ifetch_queue_if.sv | 15 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/ifetch_queue.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types: opcode constants, the fetch state enum and immediate decoders.
package fetch_pkg;

  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [1:0] RVC_OP_C1   = 2'b01;
  localparam logic [1:0] RVC_OP_C2   = 2'b10;
  localparam logic [2:0] RVC_F3_CJ   = 3'b101;
  localparam logic [2:0] RVC_F3_CJAL = 3'b001;
  localparam logic [2:0] RVC_F3_CJR  = 3'b100;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_JALR = 2'd1,
    HALT      = 2'd2
  } fetch_state_e;

  // J-type immediate from ins[31:12], sign-extended to 32 bits
  function automatic logic [31:0] imm_j(input logic [19:0] hi);
    return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

  // CJ-format immediate from ins[12:2], sign-extended to 32 bits
  function automatic logic [31:0] imm_cj(input logic [10:0] f);
    return {{21{f[10]}}, f[6], f[8:7], f[4], f[5], f[0], f[9], f[3:1], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Decoder-side valid/ready handshake of the fetch queue.
interface ifetch_queue_if #(
  parameter int XLEN = 32
) ();
  logic            dq_valid_out;
  logic [31:0]     dq_ins_out;
  logic [XLEN-1:0] dq_pc_out;
  logic [XLEN-1:0] dq_pred_pc_out;
  logic            dq_ready_in;

  modport master (output dq_valid_out, dq_ins_out, dq_pc_out, dq_pred_pc_out,
                  input  dq_ready_in);
  modport slave  (input  dq_valid_out, dq_ins_out, dq_pc_out, dq_pred_pc_out,
                  output dq_ready_in);
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer; flush wins over push/pop, head reads as zero when empty.
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: one-outstanding icache requests, direct-jump pre-decode, JALR stall, fetch queue.
// Optional compressed-instruction pre-decode is enabled by defining RVC_FETCH_EN.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  output logic                   ic_req_out,
  output logic [XLEN-1:0]        ic_pc_out,
  input  logic [31:0]            ic_ins_in,
  input  logic                   ic_valid_in,
  output logic [XLEN-1:0]        bp_pc_out,
  output logic [31:0]            bp_ins_out,
  input  logic [XLEN-1:0]        bp_next_pc_in,
  ifetch_queue_if.master         dq,
  input  logic                   redir_valid_in,
  input  logic [XLEN-1:0]        redir_pc_in,
  input  logic                   jalr_valid_in,
  input  logic [XLEN-1:0]        jalr_pc_in,
  output logic [$clog2(DEPTH):0] q_count_out
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(1);

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_pc;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d, drop_q, drop_d;
  logic            push, pop, flush, q_valid;
  entry_t          push_entry, head_entry;
  logic [CW-1:0]   count, count_next;
  logic            is_jal, is_jalr;
  logic [XLEN-1:0] step, jump_tgt;

  always_comb begin
    is_jal   = (ic_ins_in[6:0] == OP_JAL);
    is_jalr  = (ic_ins_in[6:0] == OP_JALR);
    step     = XLEN'(4);
    jump_tgt = pc_q + XLEN'(signed'(imm_j(ic_ins_in[31:12])));
`ifdef RVC_FETCH_EN
    if (ic_ins_in[1:0] != 2'b11) begin
      step     = XLEN'(2);
      is_jal   = (ic_ins_in[1:0] == RVC_OP_C1) &&
                 (ic_ins_in[15:13] == RVC_F3_CJ || ic_ins_in[15:13] == RVC_F3_CJAL);
      // C.JR / C.JALR: rs2 must be zero and rs1 non-zero, else it is C.MV/C.ADD/C.EBREAK
      is_jalr  = (ic_ins_in[1:0] == RVC_OP_C2) && (ic_ins_in[15:13] == RVC_F3_CJR) &&
                 (ic_ins_in[11:7] != 5'd0) && (ic_ins_in[6:2] == 5'd0);
      jump_tgt = pc_q + XLEN'(signed'(imm_cj(ic_ins_in[12:2])));
    end
`endif
  end

  assign q_valid = (count != '0);
  assign flush   = rdy_in && redir_valid_in;
  assign pop     = rdy_in && !redir_valid_in && q_valid && dq.dq_ready_in;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_entry = '0;
    if (rdy_in) begin
      if (redir_valid_in) begin
        state_d = FETCH;
        pc_d    = redir_pc_in & LSB_CLR;
        drop_d  = ic_valid_in ? 1'b0 : (drop_q || req_q);
      end else if (state_q == WAIT_JALR && jalr_valid_in) begin
        state_d = FETCH;
        pc_d    = jalr_pc_in & LSB_CLR;
      end else if (ic_valid_in && drop_q) begin
        drop_d = 1'b0;
      end else if (ic_valid_in && state_q == FETCH) begin
        if (ic_ins_in == 32'd0) begin
          state_d = HALT;
        end else begin
          push           = 1'b1;
          push_entry.ins = ic_ins_in;
          push_entry.pc  = pc_q;
          if (is_jal) begin
            push_entry.pred_pc = jump_tgt;
            pc_d               = jump_tgt;
          end else if (is_jalr) begin
            push_entry.pred_pc = pc_q + step;
            state_d            = WAIT_JALR;
          end else begin
            push_entry.pred_pc = bp_next_pc_in & LSB_CLR;
            pc_d               = bp_next_pc_in & LSB_CLR;
          end
        end
      end
    end
  end

  // Request is registered; the slot it will fill is already counted as free here
  always_comb begin
    count_next = count;
    req_d      = req_q;
    if (rdy_in) begin
      count_next = flush ? '0 : count + CW'(push) - CW'(pop);
      req_d      = (state_d == FETCH) && !drop_d && (count_next < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head_entry),
    .count     (count)
  );

  assign ic_req_out        = req_q;
  assign ic_pc_out         = pc_q;
  assign bp_pc_out         = pc_q;
  assign bp_ins_out        = ic_ins_in;
  assign q_count_out       = count;
  assign dq.dq_valid_out   = q_valid;
  assign dq.dq_ins_out     = head_entry.ins;
  assign dq.dq_pc_out      = head_entry.pc;
  assign dq.dq_pred_pc_out = head_entry.pred_pc;

endmodule
